// File: rtl/bist_seq_pkg.sv
// Shared types and helpers for the LBIST fault-injection campaign sequencer.
package bist_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ARM,
        RUN,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    localparam int unsigned INIT_CYCLES = 2;
    localparam int unsigned SAT_W       = 32;

    // Increment v, saturating at the all-ones value of a w-bit field.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int unsigned w);
        logic [SAT_W-1:0] max_v;
        max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        return (v >= max_v) ? max_v : (v + SAT_W'(1));
    endfunction

endpackage

// File: rtl/bist_seq_cnt.sv
// Clearable/loadable up-counter with a terminal-count compare against tc_val.
module bist_seq_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] count,
    output logic         tc_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign tc_c = (count == tc_val);

endmodule

// File: rtl/bist_campaign_seq.sv
// Fault-injection campaign sequencer: per fault re-arms the TPG, runs patterns,
// drains ORA latency, records detection and steps the injector until its last fault.
module bist_campaign_seq
    import bist_seq_pkg::*;
#(
    parameter int unsigned ERR_BITS     = 12,
    parameter int unsigned PAT_BITS     = 16,
    parameter int unsigned MAX_PATTERNS = 65535,
    parameter int unsigned ORA_LAT      = 1,
    parameter int unsigned EARLY_EXIT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                tpg_end,
    input  logic                ora_res,
    input  logic                fil_end,
    output logic                sys_rst,
    output logic                tpg_rst,
    output logic                fil_inc,
    output logic                busy,
    output logic                done,
    output logic [ERR_BITS-1:0] err_count,
    output logic [ERR_BITS-1:0] fault_idx,
    output logic [PAT_BITS-1:0] pat_count
);

    localparam int unsigned          PH_BITS  = 3;
    localparam logic [PH_BITS-1:0]   INIT_TC  = PH_BITS'(INIT_CYCLES - 1);
    localparam logic [PH_BITS-1:0]   DRAIN_TC = (ORA_LAT == 0) ? '0 : PH_BITS'(ORA_LAT - 1);
    localparam logic [PAT_BITS-1:0]  PAT_TC   = PAT_BITS'(MAX_PATTERNS - 1);

    state_t               state_q;
    state_t               state_d;
    logic                 detected_q;
    logic                 run_exit;
    logic                 ph_clr;
    logic                 ph_inc;
    logic                 ph_tc;
    logic [PH_BITS-1:0]   ph_tc_val;
    logic [PH_BITS-1:0]   ph_count;
    logic                 pat_clr;
    logic                 pat_inc;
    logic                 pat_tc;

    // Phase counter times the INIT and DRAIN dwell.
    bist_seq_cnt #(.W(PH_BITS)) u_ph_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (ph_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (ph_inc),
        .tc_val   (ph_tc_val),
        .count    (ph_count),
        .tc_c     (ph_tc)
    );

    bist_seq_cnt #(.W(PAT_BITS)) u_pat_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (pat_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (pat_inc),
        .tc_val   (PAT_TC),
        .count    (pat_count),
        .tc_c     (pat_tc)
    );

    // Next-state and counter-control decode.
    always_comb begin
        state_d   = state_q;
        run_exit  = tpg_end || pat_tc || ((EARLY_EXIT != 0) && ora_res);
        ph_tc_val = (state_q == INIT) ? INIT_TC : DRAIN_TC;
        pat_clr   = (state_q == ARM);
        pat_inc   = (state_q == RUN);
        case (state_q)
            IDLE:    if (start) state_d = INIT;
            INIT:    if (ph_tc) state_d = ARM;
            ARM:     state_d = RUN;
            RUN:     if (run_exit) state_d = (ORA_LAT == 0) ? NEXT : DRAIN;
            DRAIN:   if (ph_tc) state_d = NEXT;
            NEXT:    state_d = fil_inc ? ARM : DONE;
            DONE:    if (start) state_d = INIT;
            default: state_d = IDLE;
        endcase
        ph_clr = (state_d != state_q);
        ph_inc = (state_q == INIT) || (state_q == DRAIN);
    end

    // State register with outputs registered from the next state; fil_inc uses the
    // injector's fil_end level, which is stable for the whole fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sys_rst <= 1'b1;
            tpg_rst <= 1'b1;
            fil_inc <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            sys_rst <= (state_d == IDLE) || (state_d == INIT) || (state_d == DONE);
            tpg_rst <= (state_d != RUN);
            fil_inc <= (state_d == NEXT) && !fil_end;
            busy    <= (state_d != IDLE) && (state_d != DONE);
            done    <= (state_d == DONE);
        end
    end

    // Detection flag and campaign counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            detected_q <= 1'b0;
            err_count  <= '0;
            fault_idx  <= '0;
        end else begin
            if (state_q == ARM) begin
                detected_q <= 1'b0;
            end else if (((state_q == RUN) || (state_q == DRAIN)) && ora_res) begin
                detected_q <= 1'b1;
            end

            if (((state_q == IDLE) || (state_q == DONE)) && start) begin
                err_count <= '0;
                fault_idx <= '0;
            end else if (state_q == NEXT) begin
                if (detected_q) begin
                    err_count <= ERR_BITS'(sat_inc(SAT_W'(err_count), ERR_BITS));
                end
                if (fil_inc) begin
                    fault_idx <= ERR_BITS'(sat_inc(SAT_W'(fault_idx), ERR_BITS));
                end
            end
        end
    end

endmodule

// File: tb/tb_bist_campaign_seq.sv
// Directed bench for bist_campaign_seq: a reactive TPG/ORA/injector stub drives
// three configurations (early exit, no early exit, single-pattern with no drain).
module tb_bist_campaign_seq;

    localparam int unsigned EB = 4;
    localparam int unsigned PB = 4;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic start   = 1'b0;
    logic tpg_end = 1'b0;
    logic ora_res = 1'b0;
    logic fil_end = 1'b0;

    logic          s_sys_rst [3];
    logic          s_tpg_rst [3];
    logic          s_fil_inc [3];
    logic          s_busy    [3];
    logic          s_done    [3];
    logic [EB-1:0] s_err     [3];
    logic [EB-1:0] s_idx     [3];
    logic [PB-1:0] s_pat     [3];

    logic [1:0]    sel = 2'd0;
    logic          m_sys_rst, m_tpg_rst, m_fil_inc, m_busy, m_done;
    logic [EB-1:0] m_err, m_idx;
    logic [PB-1:0] m_pat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bist_campaign_seq #(.ERR_BITS(EB), .PAT_BITS(PB), .MAX_PATTERNS(8), .ORA_LAT(1), .EARLY_EXIT(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .tpg_end(tpg_end), .ora_res(ora_res), .fil_end(fil_end),
        .sys_rst(s_sys_rst[0]), .tpg_rst(s_tpg_rst[0]), .fil_inc(s_fil_inc[0]), .busy(s_busy[0]),
        .done(s_done[0]), .err_count(s_err[0]), .fault_idx(s_idx[0]), .pat_count(s_pat[0])
    );

    bist_campaign_seq #(.ERR_BITS(EB), .PAT_BITS(PB), .MAX_PATTERNS(8), .ORA_LAT(1), .EARLY_EXIT(0)) u_dut_ne (
        .clk(clk), .rst(rst), .start(start), .tpg_end(tpg_end), .ora_res(ora_res), .fil_end(fil_end),
        .sys_rst(s_sys_rst[1]), .tpg_rst(s_tpg_rst[1]), .fil_inc(s_fil_inc[1]), .busy(s_busy[1]),
        .done(s_done[1]), .err_count(s_err[1]), .fault_idx(s_idx[1]), .pat_count(s_pat[1])
    );

    bist_campaign_seq #(.ERR_BITS(EB), .PAT_BITS(PB), .MAX_PATTERNS(1), .ORA_LAT(0), .EARLY_EXIT(1)) u_dut_m1 (
        .clk(clk), .rst(rst), .start(start), .tpg_end(tpg_end), .ora_res(ora_res), .fil_end(fil_end),
        .sys_rst(s_sys_rst[2]), .tpg_rst(s_tpg_rst[2]), .fil_inc(s_fil_inc[2]), .busy(s_busy[2]),
        .done(s_done[2]), .err_count(s_err[2]), .fault_idx(s_idx[2]), .pat_count(s_pat[2])
    );

    always_comb begin
        m_sys_rst = s_sys_rst[sel];
        m_tpg_rst = s_tpg_rst[sel];
        m_fil_inc = s_fil_inc[sel];
        m_busy    = s_busy[sel];
        m_done    = s_done[sel];
        m_err     = s_err[sel];
        m_idx     = s_idx[sel];
        m_pat     = s_pat[sel];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; tpg_end = 1'b0; ora_res = 1'b0; fil_end = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    // Starts a campaign and plays TPG/ORA/injector against the selected DUT until done.
    task automatic campaign(input int last_fault, input int tpg_pat, input int mask,
                            input int ora_lo, input int ora_hi, input int ora_post, input bit keep_start,
                            output int cyc_done, output int incs, output int last_run,
                            output int first_pat, output bit to);
        int cyc, inj, run_ctr, since_run, p;
        bit prev_inc, got_fp, hit;
        cyc_done = 0; incs = 0; last_run = 0; first_pat = -1; to = 1'b1;
        inj = 0; run_ctr = 0; since_run = 99; prev_inc = 1'b0; got_fp = 1'b0;
        tpg_end = 1'b0; ora_res = 1'b0; fil_end = (last_fault <= 0);
        start = 1'b1;
        step();
        cyc = 1;
        start = keep_start;
        while (cyc < 2000) begin
            if (prev_inc) begin
                inj++;
                run_ctr = 0;
            end
            prev_inc = m_fil_inc;
            if (m_fil_inc) incs++;
            if (m_done) begin
                cyc_done = cyc;
                to = 1'b0;
                break;
            end
            if (!m_tpg_rst) begin
                since_run = 0;
                run_ctr++;
                last_run = run_ctr;
            end else if (since_run < 99) begin
                since_run++;
            end
            if (since_run == 1 && !got_fp) begin
                first_pat = int'(m_pat);
                got_fp = 1'b1;
            end
            p = run_ctr - 1;
            hit = (inj < 32) ? mask[inj] : 1'b0;
            fil_end = (inj >= last_fault);
            tpg_end = !m_tpg_rst && (p == tpg_pat);
            ora_res = hit && ((!m_tpg_rst && p >= ora_lo && p <= ora_hi) ||
                              (m_tpg_rst && m_busy && since_run == ora_post));
            step();
            cyc++;
        end
        start = 1'b0; tpg_end = 1'b0; ora_res = 1'b0;
    endtask

    task automatic test_reset();
        sel = 2'd0;
        rst = 1'b1; start = 1'b1;
        step(); step();
        checks++;
        if ({m_sys_rst, m_tpg_rst, m_fil_inc, m_busy, m_done} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 11000", {m_sys_rst, m_tpg_rst, m_fil_inc, m_busy, m_done});
        end
        checks++;
        if ({m_err, m_idx, m_pat} !== 12'h000) begin
            errors++;
            $display("FAIL reset_counts: got %h expected 000", {m_err, m_idx, m_pat});
        end
        rst = 1'b0; start = 1'b0;
        step(); step();
        checks++;
        if (m_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_rst: busy got %b expected 0", m_busy);
        end
    endtask

    task automatic test_rst_mid_run();
        bit found;
        do_reset();
        sel = 2'd0;
        found = 1'b0;
        fil_end = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_idx == EB'(2) && !m_tpg_rst) begin
                found = 1'b1;
                break;
            end
            tpg_end = !m_tpg_rst && (m_pat == PB'(3));
            ora_res = !m_tpg_rst && (m_pat == PB'(1));
            step();
        end
        checks++;
        if (!found || m_err !== EB'(2)) begin
            errors++;
            $display("FAIL mid_run_reach: found %0d err_count %0d expected 1 and 2", found, m_err);
        end
        tpg_end = 1'b0; ora_res = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({m_sys_rst, m_tpg_rst, m_fil_inc, m_busy} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_run_rst_flags: got %b expected 1100", {m_sys_rst, m_tpg_rst, m_fil_inc, m_busy});
        end
        checks++;
        if (m_err !== '0 || m_idx !== '0) begin
            errors++;
            $display("FAIL mid_run_rst_counts: err %0d idx %0d expected 0 0", m_err, m_idx);
        end
        rst = 1'b0;
        step();
        checks++;
        if (m_fil_inc !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_after_rst: fil_inc %b busy %b expected 0 0", m_fil_inc, m_busy);
        end
    endtask

    task automatic test_single_fault();
        int cd, incs, lr, fp;
        bit to;
        do_reset();
        sel = 2'd0;
        campaign(0, 4, 0, -1, -1, -1, 1'b0, cd, incs, lr, fp, to);
        checks++;
        if (to || cd != 11) begin
            errors++;
            $display("FAIL single_done_cycle: timeout %0d cycle %0d expected 0 11", to, cd);
        end
        checks++;
        if (incs != 0 || lr != 5 || fp != 5) begin
            errors++;
            $display("FAIL single_run: incs %0d run %0d pat %0d expected 0 5 5", incs, lr, fp);
        end
        checks++;
        if (m_err !== '0 || m_idx !== '0) begin
            errors++;
            $display("FAIL single_counts: err %0d idx %0d expected 0 0", m_err, m_idx);
        end
        step(); step(); step();
        checks++;
        if ({m_done, m_busy, m_sys_rst, m_tpg_rst} !== 4'b1011) begin
            errors++;
            $display("FAIL single_done_hold: got %b expected 1011", {m_done, m_busy, m_sys_rst, m_tpg_rst});
        end
    endtask

    task automatic test_three_faults();
        int cd, incs, lr, fp;
        bit to;
        do_reset();
        sel = 2'd0;
        campaign(2, 4, 5, 2, 2, -1, 1'b0, cd, incs, lr, fp, to);
        checks++;
        if (to || cd != 23) begin
            errors++;
            $display("FAIL three_done_cycle: timeout %0d cycle %0d expected 0 23", to, cd);
        end
        checks++;
        if (m_err !== EB'(2) || m_idx !== EB'(2) || incs != 2) begin
            errors++;
            $display("FAIL three_counts: err %0d idx %0d incs %0d expected 2 2 2", m_err, m_idx, incs);
        end
        checks++;
        if (fp != 3 || lr != 3) begin
            errors++;
            $display("FAIL three_early_exit: first pat %0d last run %0d expected 3 3", fp, lr);
        end
    endtask

    task automatic test_no_early_exit();
        int cd, incs, lr, fp;
        bit to;
        do_reset();
        sel = 2'd1;
        campaign(0, -1, 1, 1, 4, -1, 1'b1, cd, incs, lr, fp, to);
        checks++;
        if (to || cd != 14) begin
            errors++;
            $display("FAIL noee_done_cycle: timeout %0d cycle %0d expected 0 14", to, cd);
        end
        checks++;
        if (lr != 8 || fp != 8) begin
            errors++;
            $display("FAIL noee_cap: run %0d pat %0d expected 8 8", lr, fp);
        end
        checks++;
        if (m_err !== EB'(1) || incs != 0) begin
            errors++;
            $display("FAIL noee_count: err %0d incs %0d expected 1 0", m_err, incs);
        end
    endtask

    task automatic test_drain_detect();
        int cd, incs, lr, fp;
        bit to;
        do_reset();
        sel = 2'd0;
        campaign(0, 4, 1, -1, -1, 1, 1'b0, cd, incs, lr, fp, to);
        checks++;
        if (to || m_err !== EB'(1)) begin
            errors++;
            $display("FAIL drain_counted: timeout %0d err %0d expected 0 1", to, m_err);
        end
        campaign(0, 4, 1, -1, -1, 2, 1'b0, cd, incs, lr, fp, to);
        checks++;
        if (to || m_err !== EB'(0)) begin
            errors++;
            $display("FAIL next_ignored: timeout %0d err %0d expected 0 0", to, m_err);
        end
        campaign(0, 4, 1, 4, 4, -1, 1'b0, cd, incs, lr, fp, to);
        checks++;
        if (to || m_err !== EB'(1) || lr != 5) begin
            errors++;
            $display("FAIL same_cycle_end: timeout %0d err %0d run %0d expected 0 1 5", to, m_err, lr);
        end
    endtask

    task automatic test_saturation();
        int cd, incs, lr, fp;
        bit to;
        do_reset();
        sel = 2'd0;
        campaign(19, 0, 32'h000F_FFFF, 0, 0, -1, 1'b0, cd, incs, lr, fp, to);
        checks++;
        if (to || cd != 83 || incs != 19) begin
            errors++;
            $display("FAIL sat_run: timeout %0d cycle %0d incs %0d expected 0 83 19", to, cd, incs);
        end
        checks++;
        if (m_err !== EB'(15) || m_idx !== EB'(15) || m_done !== 1'b1) begin
            errors++;
            $display("FAIL sat_counts: err %0d idx %0d done %b expected 15 15 1", m_err, m_idx, m_done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (m_err !== '0 || m_idx !== '0 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: err %0d idx %0d busy %b expected 0 0 1", m_err, m_idx, m_busy);
        end
    endtask

    task automatic test_max1();
        int cd, incs, lr, fp;
        bit to;
        do_reset();
        sel = 2'd2;
        campaign(0, -1, 1, 0, 0, -1, 1'b0, cd, incs, lr, fp, to);
        checks++;
        if (to || cd != 6 || lr != 1) begin
            errors++;
            $display("FAIL max1_run: timeout %0d cycle %0d run %0d expected 0 6 1", to, cd, lr);
        end
        checks++;
        if (fp != 1 || m_err !== EB'(1)) begin
            errors++;
            $display("FAIL max1_count: pat %0d err %0d expected 1 1", fp, m_err);
        end
    endtask

    initial begin
        test_reset();
        test_rst_mid_run();
        test_single_fault();
        test_three_faults();
        test_no_early_exit();
        test_drain_detect();
        test_saturation();
        test_max1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1);
    end

endmodule
